// File: rtl/plic_gen.sv
// plic_gen: platform-level interrupt controller with a Wishbone slave port.
// NSRC sources feed per-source gateways. The gateways feed a priority/threshold
// arbiter and a claim/complete protocol that tracks which sources are in flight.
// Optional build macro PLIC_EDGE_TRIG_EN adds a per-source edge_mode register at 0x3000.
module plic_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h0C000000,
  parameter int unsigned NSRC      = 8,
  parameter int unsigned PRIO_W    = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic [NSRC-1:0]  irq_src_i,
  input  logic [31:0]      csr_mie,
  input  logic [31:0]      csr_mstatus,
  output logic             Interrupt,
  output logic [30:0]      Exception_code
);

  localparam logic [31:0] OFF_PEND  = 32'h0000_1000;
  localparam logic [31:0] OFF_EN    = 32'h0000_2000;
  localparam logic [31:0] OFF_EMODE = 32'h0000_3000;
  localparam logic [31:0] OFF_THR   = 32'h0020_0000;
  localparam logic [31:0] OFF_CLAIM = 32'h0020_0004;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              irq_q, irq_d;
  logic [30:0]       code_q, code_d;
  logic [NSRC:1]     pend_q, pend_d;
  logic [NSRC:1]     infl_q, infl_d;
  logic [NSRC:1]     en_q, en_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [PRIO_W-1:0] prio_q [1:NSRC];
  logic [PRIO_W-1:0] prio_d [1:NSRC];
`ifdef PLIC_EDGE_TRIG_EN
  logic [NSRC:1]     emode_q, emode_d;
  logic [NSRC:1]     prev_q, prev_d;
  logic [NSRC:1]     held_q, held_d;
`endif

  logic [31:0]       off;
  logic              req, wr, rd;
  logic [4:0]        winner;
  logic [PRIO_W-1:0] best;
  logic [31:0]       rdata;
  logic              unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_dat_i, csr_mie, csr_mstatus};
  assign off = wb_adr_i - BASE_ADDR;
  assign req = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = req & wb_we_i;
  assign rd  = req & ~wb_we_i;

  // Arbiter: highest enabled pending priority above threshold; strict > keeps lowest id on ties.
  always_comb begin
    winner = '0;
    best   = thr_q;
    for (int unsigned i = 1; i <= NSRC; i++) begin
      if (pend_q[i] && en_q[i] && (prio_q[i] > best)) begin
        winner = 5'(i);
        best   = prio_q[i];
      end
    end
  end

  // Read-data mux for the register window.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 1; i <= NSRC; i++) begin
      if (off == 32'(4 * i)) rdata = 32'(prio_q[i]);
    end
    if (off == OFF_PEND)  rdata = 32'({pend_q, 1'b0});
    if (off == OFF_EN)    rdata = 32'({en_q, 1'b0});
`ifdef PLIC_EDGE_TRIG_EN
    if (off == OFF_EMODE) rdata = 32'({emode_q, 1'b0});
`endif
    if (off == OFF_THR)   rdata = 32'(thr_q);
    if (off == OFF_CLAIM) rdata = 32'(winner);
  end

  // Next-state: bus side effects, gateways, claim/complete and interrupt output.
  always_comb begin
    ack_d  = req;
    dat_d  = dat_q;
    pend_d = pend_q;
    infl_d = infl_q;
    en_d   = en_q;
    thr_d  = thr_q;
    prio_d = prio_q;
`ifdef PLIC_EDGE_TRIG_EN
    emode_d = emode_q;
    prev_d  = irq_src_i;
    held_d  = held_q;
`endif

    if (rd) dat_d = rdata;

    if (wr) begin
      for (int unsigned i = 1; i <= NSRC; i++) begin
        if (off == 32'(4 * i)) prio_d[i] = wb_dat_i[PRIO_W-1:0];
      end
      if (off == OFF_EN)    en_d    = wb_dat_i[NSRC:1];
`ifdef PLIC_EDGE_TRIG_EN
      if (off == OFF_EMODE) emode_d = wb_dat_i[NSRC:1];
`endif
      if (off == OFF_THR)   thr_d   = wb_dat_i[PRIO_W-1:0];
    end

    // Complete is evaluated before the gateways so that an edge arriving in the
    // same cycle as a held re-pend is recorded as a fresh held edge, not dropped.
    if (wr && (off == OFF_CLAIM)) begin
      for (int unsigned i = 1; i <= NSRC; i++) begin
        if ((wb_dat_i[4:0] == 5'(i)) && infl_q[i]) begin
          infl_d[i] = 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
          if (held_q[i]) begin
            pend_d[i] = 1'b1;
            held_d[i] = 1'b0;
          end
`endif
        end
      end
    end

    for (int unsigned i = 1; i <= NSRC; i++) begin
`ifdef PLIC_EDGE_TRIG_EN
      if (emode_q[i]) begin
        if (irq_src_i[i-1] && !prev_q[i]) begin
          if (!pend_q[i] && !infl_q[i]) pend_d[i] = 1'b1;
          else                          held_d[i] = 1'b1;
        end
      end else
`endif
      if (irq_src_i[i-1] && !pend_q[i] && !infl_q[i]) pend_d[i] = 1'b1;
    end

    if (rd && (off == OFF_CLAIM) && (winner != '0)) begin
      for (int unsigned i = 1; i <= NSRC; i++) begin
        if (winner == 5'(i)) begin
          pend_d[i] = 1'b0;
          infl_d[i] = 1'b1;
        end
      end
    end

    irq_d  = (winner != '0) & csr_mstatus[3] & csr_mie[11];
    code_d = irq_d ? 31'd11 : '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
      code_q  <= '0;
      pend_q  <= '0;
      infl_q  <= '0;
      en_q    <= '0;
      thr_q   <= '0;
      prio_q  <= '{default: '0};
`ifdef PLIC_EDGE_TRIG_EN
      emode_q <= '0;
      prev_q  <= '0;
      held_q  <= '0;
`endif
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      infl_q  <= infl_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      prio_q  <= prio_d;
`ifdef PLIC_EDGE_TRIG_EN
      emode_q <= emode_d;
      prev_q  <= prev_d;
      held_q  <= held_d;
`endif
    end
  end

  assign wb_ack_o       = ack_q;
  assign wb_dat_o       = dat_q;
  assign Interrupt      = irq_q;
  assign Exception_code = code_q;

endmodule
